// File: rtl/riscv_imm_pkg.sv
// Shared immediate-format types, range limits and field masks for the instruction packer.
package riscv_imm_pkg;

    typedef enum logic [1:0] {
        IMM_I = 2'b00,
        IMM_S = 2'b01,
        IMM_B = 2'b10,
        IMM_J = 2'b11
    } imm_src_t;

    localparam int IMM_I_MIN = -2048;
    localparam int IMM_I_MAX = 2047;
    localparam int IMM_B_MIN = -4096;
    localparam int IMM_B_MAX = 4094;
    localparam int IMM_J_MIN = -1048576;
    localparam int IMM_J_MAX = 1048574;

    // Bits of the instruction word owned by the immediate in each format.
    localparam logic [31:0] MASK_I = 32'hFFF0_0000;
    localparam logic [31:0] MASK_S = 32'hFE00_0F80;
    localparam logic [31:0] MASK_B = 32'hFE00_0F80;
    localparam logic [31:0] MASK_J = 32'hFFFF_F000;

    function automatic logic [31:0] field_mask(input imm_src_t src);
        case (src)
            IMM_I:   return MASK_I;
            IMM_S:   return MASK_S;
            IMM_B:   return MASK_B;
            default: return MASK_J;
        endcase
    endfunction

endpackage

// File: rtl/imm_field_encode.sv
// Combinational scatter of a signed immediate into the I/S/B/J bit positions of a base word.
// Range/alignment flagging is present only when IMM_RANGE_CHECK_EN is defined.
module imm_field_encode
    import riscv_imm_pkg::*;
(
    input  logic [1:0]  i_imm_src,
    input  logic [31:0] i_imm,
    input  logic [31:0] i_base,
    output logic [31:0] o_word,
    output logic        o_err
);

    imm_src_t    w_src;
    logic [31:0] w_field;

    assign w_src = imm_src_t'(i_imm_src);

    always_comb begin
        w_field = '0;
        case (w_src)
            IMM_I:   w_field = {i_imm[11:0], 20'b0};
            IMM_S:   w_field = {i_imm[11:5], 13'b0, i_imm[4:0], 7'b0};
            IMM_B:   w_field = {i_imm[12], i_imm[10:5], 13'b0, i_imm[4:1], i_imm[11], 7'b0};
            default: w_field = {i_imm[20], i_imm[10:1], i_imm[11], i_imm[19:12], 12'b0};
        endcase
    end

    assign o_word = (i_base & ~field_mask(w_src)) | w_field;

`ifdef IMM_RANGE_CHECK_EN
    logic signed [31:0] w_imm_s;
    assign w_imm_s = $signed(i_imm);

    always_comb begin
        o_err = 1'b0;
        case (w_src)
            IMM_I, IMM_S: o_err = (w_imm_s < IMM_I_MIN) || (w_imm_s > IMM_I_MAX);
            IMM_B:        o_err = (w_imm_s < IMM_B_MIN) || (w_imm_s > IMM_B_MAX) || i_imm[0];
            default:      o_err = (w_imm_s < IMM_J_MIN) || (w_imm_s > IMM_J_MAX) || i_imm[0];
        endcase
    end
`else
    // Upper immediate bits only matter to the range check.
    logic w_unused_imm_hi;
    assign w_unused_imm_hi = ^i_imm[31:21];
    assign o_err = 1'b0;
`endif

endmodule

// File: rtl/instr_imm_packer.sv
// Packs immediates into instruction words and buffers them in a valid/ready FIFO with counters.
// Optional per-entry range/alignment flag when IMM_RANGE_CHECK_EN is defined.
module instr_imm_packer
    import riscv_imm_pkg::*;
#(
    parameter int DEPTH = 2,
    parameter int CNT_W = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             InValid,
    output logic             InReady,
    input  logic [1:0]       ImmSrc,
    input  logic [31:0]      ImmIn,
    input  logic [31:0]      BaseInstr,
    output logic             OutValid,
    input  logic             OutReady,
    output logic [31:0]      InstrOut,
    output logic             ImmErr,
    output logic [CNT_W-1:0] PackCount,
    output logic [CNT_W-1:0] ErrCount
);

    localparam int AW = $clog2(DEPTH);

    logic [AW:0]      r_wr_ptr;
    logic [AW:0]      r_rd_ptr;
    logic [31:0]      r_mem_word [DEPTH];
    logic             r_mem_err  [DEPTH];
    logic [31:0]      r_head_word;
    logic             r_head_err;
    logic [CNT_W-1:0] r_pack_cnt;
    logic [CNT_W-1:0] r_err_cnt;

    logic [31:0]      w_enc_word;
    logic             w_enc_err;
    logic [AW:0]      w_count;
    logic             w_empty;
    logic             w_full;
    logic             w_push;
    logic             w_pop;
    logic [AW-1:0]    w_rd_next_idx;
    logic [31:0]      w_head_word_next;
    logic             w_head_err_next;

    imm_field_encode u_encode (
        .i_imm_src (ImmSrc),
        .i_imm     (ImmIn),
        .i_base    (BaseInstr),
        .o_word    (w_enc_word),
        .o_err     (w_enc_err)
    );

    assign w_count       = r_wr_ptr - r_rd_ptr;
    assign w_empty       = (r_wr_ptr == r_rd_ptr);
    assign w_full        = (r_wr_ptr[AW] != r_rd_ptr[AW]) &&
                           (r_wr_ptr[AW-1:0] == r_rd_ptr[AW-1:0]);
    assign w_push        = InValid && !w_full;
    assign w_pop         = OutReady && !w_empty;
    assign w_rd_next_idx = r_rd_ptr[AW-1:0] + AW'(1);

    genvar gi;
    generate
        for (gi = 0; gi < DEPTH; gi++) begin : g_mem
            always_ff @(posedge clk) begin
                if (w_push && (r_wr_ptr[AW-1:0] == AW'(gi))) begin
                    r_mem_word[gi] <= w_enc_word;
                    r_mem_err[gi]  <= w_enc_err;
                end
            end
        end
    endgenerate

    // Registered head: a new value is loaded only on pop, or on push into an empty FIFO;
    // a push landing in the slot that becomes the head is bypassed straight from the encoder.
    always_comb begin
        w_head_word_next = r_head_word;
        w_head_err_next  = r_head_err;
        if (w_pop) begin
            if (w_count > (AW+1)'(1)) begin
                w_head_word_next = r_mem_word[w_rd_next_idx];
                w_head_err_next  = r_mem_err[w_rd_next_idx];
            end else if (w_push) begin
                w_head_word_next = w_enc_word;
                w_head_err_next  = w_enc_err;
            end
        end else if (w_empty && w_push) begin
            w_head_word_next = w_enc_word;
            w_head_err_next  = w_enc_err;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_wr_ptr    <= '0;
            r_rd_ptr    <= '0;
            r_head_word <= '0;
            r_head_err  <= 1'b0;
            r_pack_cnt  <= '0;
            r_err_cnt   <= '0;
        end else begin
            r_head_word <= w_head_word_next;
            r_head_err  <= w_head_err_next;
            if (w_push) begin
                r_wr_ptr   <= r_wr_ptr + (AW+1)'(1);
                r_pack_cnt <= r_pack_cnt + CNT_W'(1);
                if (w_enc_err && (r_err_cnt != {CNT_W{1'b1}})) begin
                    r_err_cnt <= r_err_cnt + CNT_W'(1);
                end
            end
            if (w_pop) begin
                r_rd_ptr <= r_rd_ptr + (AW+1)'(1);
            end
        end
    end

    assign InReady   = !w_full;
    assign OutValid  = !w_empty;
    assign InstrOut  = r_head_word;
    assign ImmErr    = r_head_err;
    assign PackCount = r_pack_cnt;
    assign ErrCount  = r_err_cnt;

endmodule

// File: tb/tb_instr_imm_packer.sv
// Self-checking bench for instr_imm_packer: directed format cases, backpressure and a
// randomized round-trip against a decode-based reference model.
module tb_instr_imm_packer;

    localparam int DEPTH = 2;
    localparam int CNT_W = 16;

    logic             clk;
    logic             rst_n;
    logic             InValid;
    logic             InReady;
    logic [1:0]       ImmSrc;
    logic [31:0]      ImmIn;
    logic [31:0]      BaseInstr;
    logic             OutValid;
    logic             OutReady;
    logic [31:0]      InstrOut;
    logic             ImmErr;
    logic [CNT_W-1:0] PackCount;
    logic [CNT_W-1:0] ErrCount;

    instr_imm_packer #(.DEPTH(DEPTH), .CNT_W(CNT_W)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .InValid   (InValid),
        .InReady   (InReady),
        .ImmSrc    (ImmSrc),
        .ImmIn     (ImmIn),
        .BaseInstr (BaseInstr),
        .OutValid  (OutValid),
        .OutReady  (OutReady),
        .InstrOut  (InstrOut),
        .ImmErr    (ImmErr),
        .PackCount (PackCount),
        .ErrCount  (ErrCount)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [1:0]  src;
        int          imm;
        logic [31:0] base;
        bit          err;
    } desc_t;

    desc_t q[$];
    int    n_pass = 0;
    int    n_chk  = 0;
    int    exp_pack = 0;
    int    exp_errc = 0;

    // Reference: value an instruction word's immediate field decodes to.
    function automatic int decode_imm(input logic [31:0] w, input logic [1:0] s);
        int u;
        case (s)
            2'b00: begin u = int'(w[31:20]); return (u >= 2048) ? u - 4096 : u; end
            2'b01: begin u = int'(w[31:25]) * 32 + int'(w[11:7]); return (u >= 2048) ? u - 4096 : u; end
            2'b10: begin
                u = int'(w[31]) * 4096 + int'(w[7]) * 2048 + int'(w[30:25]) * 32 + int'(w[11:8]) * 2;
                return (u >= 4096) ? u - 8192 : u;
            end
            default: begin
                u = int'(w[31]) * 1048576 + int'(w[19:12]) * 4096 + int'(w[20]) * 2048 + int'(w[30:21]) * 2;
                return (u >= 1048576) ? u - 2097152 : u;
            end
        endcase
    endfunction

    // Reference: what the immediate should decode to after modular truncation.
    function automatic int trunc_imm(input int imm, input logic [1:0] s);
        int m;
        int u;
        m = (s == 2'b00 || s == 2'b01) ? 4096 : (s == 2'b10) ? 8192 : 2097152;
        u = ((imm % m) + m) % m;
        if (s[1]) u = u - (u % 2);
        return (u >= m / 2) ? u - m : u;
    endfunction

    function automatic logic [31:0] imm_bits(input logic [1:0] s);
        logic [31:0] mk;
        case (s)
            2'b00:   mk = 32'hFFF00000;
            2'b01:   mk = 32'hFE000F80;
            2'b10:   mk = 32'hFE000F80;
            default: mk = 32'hFFFFF000;
        endcase
        return mk;
    endfunction

    function automatic bit model_err(input int imm, input logic [1:0] s);
`ifdef IMM_RANGE_CHECK_EN
        case (s)
            2'b00, 2'b01: return (imm < -2048) || (imm > 2047);
            2'b10:        return (imm < -4096) || (imm > 4094) || (imm % 2 != 0);
            default:      return (imm < -1048576) || (imm > 1048574) || (imm % 2 != 0);
        endcase
`else
        return (imm != imm) || (s != s);
`endif
    endfunction

    // One clock of stimulus plus scoreboard bookkeeping; callers do the comparisons.
    task automatic step(input bit v, input logic [1:0] s, input int imm, input logic [31:0] base,
                        input bit ordy, output bit accepted, output bit popped,
                        output logic [31:0] got_word, output bit got_err,
                        output bit have_exp, output desc_t e);
        desc_t d;
        InValid   = v;
        ImmSrc    = s;
        ImmIn     = imm;
        BaseInstr = base;
        OutReady  = ordy;
        accepted  = v && InReady;
        popped    = OutValid && ordy;
        got_word  = InstrOut;
        got_err   = ImmErr;
        have_exp  = 1'b0;
        e         = '{src: 2'b00, imm: 0, base: 32'h0, err: 1'b0};
        if (popped && q.size() > 0) begin
            e = q.pop_front();
            have_exp = 1'b1;
        end
        if (accepted) begin
            d = '{src: s, imm: imm, base: base, err: model_err(imm, s)};
            q.push_back(d);
            exp_pack++;
            if (d.err) exp_errc++;
        end
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        InValid = 1'b0; OutReady = 1'b0; ImmSrc = 2'b00; ImmIn = '0; BaseInstr = '0;
        rst_n = 1'b0;
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        q.delete();
        exp_pack = 0;
        exp_errc = 0;
    endtask

    task automatic check_entry(input string tag, input bit popped, input logic [31:0] got_word,
                               input bit got_err, input bit have_exp, input desc_t e);
        if (!popped) return;
        n_chk++;
        if (!have_exp) begin
            $display("FAIL %s extra_pop got=%08h required=none", tag, got_word);
        end else if (decode_imm(got_word, e.src) !== trunc_imm(e.imm, e.src) ||
                     (got_word & ~imm_bits(e.src)) !== (e.base & ~imm_bits(e.src))) begin
            $display("FAIL %s word src=%0d imm=%0d base=%08h got=%08h decoded=%0d required=%0d",
                     tag, e.src, e.imm, e.base, got_word, decode_imm(got_word, e.src),
                     trunc_imm(e.imm, e.src));
        end else begin
            n_pass++;
        end
        if (have_exp) begin
            n_chk++;
            if (got_err !== e.err)
                $display("FAIL %s err imm=%0d got=%0b required=%0b", tag, e.imm, got_err, e.err);
            else
                n_pass++;
        end
    endtask

    bit          acc, pop, gerr, hexp;
    logic [31:0] gword;
    desc_t       ex;

    task automatic test_reset();
        do_reset();
        n_chk++;
        if (OutValid !== 1'b0 || InReady !== 1'b1 || PackCount !== 0 || ErrCount !== 0 ||
            InstrOut !== 32'h0 || ImmErr !== 1'b0) begin
            $display("FAIL reset_state ov=%0b ir=%0b pc=%0d ec=%0d io=%08h ie=%0b required=0,1,0,0,0,0",
                     OutValid, InReady, PackCount, ErrCount, InstrOut, ImmErr);
        end else n_pass++;
        step(1, 2'b00, 5, 32'h13, 0, acc, pop, gword, gerr, hexp, ex);
        step(1, 2'b01, 7, 32'h23, 0, acc, pop, gword, gerr, hexp, ex);
        InValid = 1'b0;
        n_chk++;
        if (OutValid !== 1'b1 || PackCount !== 2) begin
            $display("FAIL pre_reset ov=%0b pc=%0d required=1,2", OutValid, PackCount);
        end else n_pass++;
        rst_n = 1'b0;
        #1;
        n_chk++;
        if (OutValid !== 1'b0 || InReady !== 1'b1 || PackCount !== 0) begin
            $display("FAIL async_reset ov=%0b ir=%0b pc=%0d required=0,1,0", OutValid, InReady, PackCount);
        end else n_pass++;
        $display("reset mid-stream: ov=%0b ir=%0b pc=%0d", OutValid, InReady, PackCount);
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        q.delete();
        exp_pack = 0;
        exp_errc = 0;
    endtask

    task automatic test_i_type();
        do_reset();
        step(1, 2'b00, -1, 32'h00000013, 0, acc, pop, gword, gerr, hexp, ex);
        InValid = 1'b0;
        n_chk++;
        if (OutValid !== 1'b1 || InstrOut !== 32'hFFF00013 || ImmErr !== 1'b0) begin
            $display("FAIL i_type ov=%0b got=%08h err=%0b required=1,fff00013,0", OutValid, InstrOut, ImmErr);
        end else n_pass++;
        $display("I addi imm=-1 -> %08h", InstrOut);
        step(0, 2'b00, 0, 0, 1, acc, pop, gword, gerr, hexp, ex);
        check_entry("i_type_pop", pop, gword, gerr, hexp, ex);
        n_chk++;
        if (OutValid !== 1'b0) $display("FAIL i_type_empty ov=%0b required=0", OutValid);
        else n_pass++;
    endtask

    task automatic test_bj();
        do_reset();
        step(1, 2'b10, -4, 32'h00000063, 0, acc, pop, gword, gerr, hexp, ex);
        step(1, 2'b11, 2048, 32'h0000006F, 0, acc, pop, gword, gerr, hexp, ex);
        InValid = 1'b0;
        n_chk++;
        if (InstrOut !== 32'hFE000EE3) $display("FAIL b_type got=%08h required=fe000ee3", InstrOut);
        else n_pass++;
        $display("B imm=-4 -> %08h", InstrOut);
        step(0, 2'b00, 0, 0, 1, acc, pop, gword, gerr, hexp, ex);
        OutReady = 1'b0;
        n_chk++;
        if (OutValid !== 1'b1 || InstrOut !== 32'h0010006F)
            $display("FAIL j_type ov=%0b got=%08h required=1,0010006f", OutValid, InstrOut);
        else n_pass++;
        $display("J imm=2048 -> %08h", InstrOut);
        step(0, 2'b00, 0, 0, 1, acc, pop, gword, gerr, hexp, ex);
    endtask

    task automatic test_backpressure();
        int pushed;
        int idx;
        int cyc;
        int n_more;
        int imms[8];
        do_reset();
        n_more = 6;
        for (int i = 0; i < 8; i++) imms[i] = 100 * (i + 1);
        pushed = 0;
        for (int i = 0; i < 10 && InReady; i++) begin
            step(1, 2'b00, imms[pushed], 32'h13 + i, 0, acc, pop, gword, gerr, hexp, ex);
            if (acc) pushed++;
        end
        n_chk++;
        if (pushed !== DEPTH || InReady !== 1'b0)
            $display("FAIL fill pushed=%0d ir=%0b required=%0d,0", pushed, InReady, DEPTH);
        else n_pass++;
        idx = 0;
        step(1, 2'b00, imms[DEPTH], 32'h93, 1, acc, pop, gword, gerr, hexp, ex);
        check_entry("bp_first", pop, gword, gerr, hexp, ex);
        $display("backpressure pop word=%08h", gword);
        n_chk++;
        if (acc || InReady !== 1'b1)
            $display("FAIL ready_after_pop acc=%0b ir=%0b required=0,1", acc, InReady);
        else n_pass++;
        cyc = 0;
        while ((idx < n_more || q.size() > 0) && cyc < 100) begin
            step(idx < n_more, 2'b00, imms[DEPTH + (idx % 6)], 32'h93, 1, acc, pop, gword, gerr, hexp, ex);
            check_entry("bp_order", pop, gword, gerr, hexp, ex);
            if (pop) $display("backpressure pop word=%08h", gword);
            if (acc) idx++;
            cyc++;
        end
        InValid = 1'b0;
        n_chk++;
        if (cyc >= 100 || PackCount !== DEPTH + n_more || OutValid !== 1'b0)
            $display("FAIL bp_total cyc=%0d pc=%0d ov=%0b required=%0d,0", cyc, PackCount, OutValid, DEPTH + n_more);
        else n_pass++;
    endtask

    task automatic test_range_check();
        bit e_i;
        bit e_b;
        do_reset();
        e_i = model_err(2048, 2'b00);
        e_b = model_err(3, 2'b10);
        step(1, 2'b00, 2048, 32'h13, 0, acc, pop, gword, gerr, hexp, ex);
        InValid = 1'b0;
        n_chk++;
        if (InstrOut[31:20] !== 12'h800 || ImmErr !== e_i || ErrCount !== CNT_W'(exp_errc))
            $display("FAIL range_i got=%08h err=%0b ec=%0d required=800xxxxx,%0b,%0d",
                     InstrOut, ImmErr, ErrCount, e_i, exp_errc);
        else n_pass++;
        $display("I imm=2048 -> %08h err=%0b", InstrOut, ImmErr);
        step(0, 2'b00, 0, 0, 1, acc, pop, gword, gerr, hexp, ex);
        step(1, 2'b10, 3, 32'h63, 0, acc, pop, gword, gerr, hexp, ex);
        InValid = 1'b0;
        n_chk++;
        if (InstrOut !== 32'h00000163 || ImmErr !== e_b)
            $display("FAIL range_b got=%08h err=%0b required=00000163,%0b", InstrOut, ImmErr, e_b);
        else n_pass++;
        $display("B imm=3 -> %08h err=%0b", InstrOut, ImmErr);
        step(0, 2'b00, 0, 0, 1, acc, pop, gword, gerr, hexp, ex);
    endtask

    task automatic test_random();
        int n_desc;
        int cyc;
        logic [1:0] s;
        int imm;
        logic [31:0] base;
        do_reset();
        n_desc = 0;
        cyc = 0;
        s = 2'($urandom_range(0, 3));
        imm = 0;
        base = $urandom;
        while ((n_desc < 10000 || q.size() > 0) && cyc < 60000) begin
            if ($urandom_range(0, 15) == 0) imm = int'($urandom);
            else if (s == 2'b00 || s == 2'b01) imm = int'($urandom_range(0, 4095)) - 2048;
            else if (s == 2'b10) imm = (int'($urandom_range(0, 4095)) - 2048) * 2;
            else imm = (int'($urandom_range(0, 1048575)) - 524288) * 2;
            step((n_desc < 10000) && ($urandom_range(0, 4) != 0), s, imm, base,
                 $urandom_range(0, 1) == 1, acc, pop, gword, gerr, hexp, ex);
            check_entry("random", pop, gword, gerr, hexp, ex);
            if (pop) $display("rand pop src=%0d imm=%0d word=%08h err=%0b", ex.src, ex.imm, gword, gerr);
            if (acc) begin
                n_desc++;
                s = 2'($urandom_range(0, 3));
                base = $urandom;
            end
            cyc++;
        end
        InValid = 1'b0;
        OutReady = 1'b0;
        n_chk++;
        if (cyc >= 60000 || PackCount !== CNT_W'(exp_pack) || ErrCount !== CNT_W'(exp_errc))
            $display("FAIL random_counts cyc=%0d pc=%0d ec=%0d required=%0d,%0d",
                     cyc, PackCount, ErrCount, exp_pack, exp_errc);
        else n_pass++;
    endtask

    initial begin
        rst_n = 1'b0;
        InValid = 1'b0; OutReady = 1'b0; ImmSrc = 2'b00; ImmIn = '0; BaseInstr = '0;
        repeat (2) @(posedge clk);
        #1;
        rst_n = 1'b1;
        test_reset();
        test_i_type();
        test_bj();
        test_backpressure();
        test_range_check();
        test_random();
        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
